// File: rtl/ddr2_ctrl_pkg.sv
// Shared constants and types for the DDR2 HP controller refresh path.
// CSR map, scheduler states and default timing values.
package ddr2_ctrl_pkg;

    localparam logic [1:0] CSR_CTRL   = 2'd0;
    localparam logic [1:0] CSR_TREFI  = 2'd1;
    localparam logic [1:0] CSR_TRFC   = 2'd2;
    localparam logic [1:0] CSR_STATUS = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_HOLD = 2'd2
    } state_e;

    localparam int TREFI_DEFAULT_C = 1170;
    localparam int TRFC_DEFAULT_C  = 16;
    localparam int MAX_POSTPONE_C  = 8;
    localparam int URGENT_LEVEL_C  = 6;
    localparam int CNT_BITS_C      = 16;

    // Hold lasts max(trfc,1) clks, so the counter starts one below.
    function automatic logic [6:0] hold_load(input logic [6:0] trfc);
        return (trfc == 7'd0) ? 7'd0 : trfc - 7'd1;
    endfunction

endpackage

// File: rtl/ddr2_interval_timer.sv
// Loadable down-counter; tc pulses at zero and the count reloads.
// Used for both the refresh interval and the post-refresh hold-off.
module ddr2_interval_timer #(
    parameter int             W       = 16,
    parameter logic [W-1:0]   RST_VAL = '0
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         en,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic         tc
);

    logic [W-1:0] count_q;
    logic [W-1:0] count_d;

    assign tc = en & ~load & (count_q == '0);

    always_comb begin
        count_d = count_q;
        if (load || tc) begin
            count_d = load_val;
        end else if (en) begin
            count_d = count_q - W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            count_q <= RST_VAL;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/ddr2_refresh_scheduler.sv
// Refresh scheduler: programmable tREFI/tRFC, debt-based postponement
// while busy, forced refresh once the debt reaches the urgent level.
module ddr2_refresh_scheduler
    import ddr2_ctrl_pkg::*;
#(
    parameter int TREFI_DEFAULT = TREFI_DEFAULT_C,
    parameter int TRFC_DEFAULT  = TRFC_DEFAULT_C,
    parameter int MAX_POSTPONE  = MAX_POSTPONE_C,
    parameter int URGENT_LEVEL  = URGENT_LEVEL_C,
    parameter int CNT_BITS      = CNT_BITS_C
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        init_done,
    input  logic        busy,
    input  logic        cfg_wr,
    input  logic [1:0]  cfg_addr,
    input  logic [15:0] cfg_wdata,
    output logic [15:0] cfg_rdata,
    output logic        refresh_req,
    input  logic        refresh_ack,
    output logic [3:0]  debt,
    output logic        overflow
);

    localparam logic [CNT_BITS-1:0] TWO = CNT_BITS'(2);

    logic                enable_q, enable_d;
    logic [CNT_BITS-1:0] trefi_q, trefi_d;
    logic [6:0]          trfc_q, trfc_d;
    logic [3:0]          debt_q, debt_d;
    logic                overflow_q, overflow_d;
    logic                req_q, req_d;
    logic [15:0]         rdata_q, rdata_d;
    state_e              state_q, state_d;

    logic                tick, hold_done, ack_acc;
    logic                ovf_set, ovf_clr, sat;
    logic [CNT_BITS-1:0] wtrefi;

    assign ack_acc = (state_q == ST_REQ) & refresh_ack;
    assign sat     = (debt_q == 4'(MAX_POSTPONE));
    assign wtrefi  = cfg_wdata[CNT_BITS-1:0];

    ddr2_interval_timer #(
        .W       (CNT_BITS),
        .RST_VAL (CNT_BITS'(TREFI_DEFAULT - 1))
    ) u_refi (
        .clk      (clk),
        .reset    (reset),
        .en       (init_done & enable_q),
        .load     (~init_done),
        .load_val (trefi_q - CNT_BITS'(1)),
        .tc       (tick)
    );

    ddr2_interval_timer #(
        .W       (7),
        .RST_VAL (7'd0)
    ) u_rfc (
        .clk      (clk),
        .reset    (reset),
        .en       (state_q == ST_HOLD),
        .load     (ack_acc),
        .load_val (hold_load(trfc_q)),
        .tc       (hold_done)
    );

    always_comb begin
        enable_d = enable_q;
        trefi_d  = trefi_q;
        trfc_d   = trfc_q;
        ovf_clr  = 1'b0;
        if (cfg_wr) begin
            unique case (cfg_addr)
                CSR_CTRL: begin
                    enable_d = cfg_wdata[0];
                    ovf_clr  = cfg_wdata[8];
                end
                CSR_TREFI: trefi_d = (wtrefi < TWO) ? TWO : wtrefi;
                CSR_TRFC:  trfc_d  = cfg_wdata[6:0];
                default:   ;
            endcase
        end
        unique case (cfg_addr)
            CSR_CTRL:  rdata_d = {7'd0, overflow_q, 7'd0, enable_q};
            CSR_TREFI: rdata_d = 16'(trefi_q);
            CSR_TRFC:  rdata_d = {9'd0, trfc_q};
            default:   rdata_d = {10'd0, state_q, debt_q};
        endcase
    end

    // A tick and an accepted ack in the same clk cancel out.
    always_comb begin
        debt_d  = debt_q;
        ovf_set = 1'b0;
        if (!init_done) begin
            debt_d = 4'd0;
        end else if (tick && !ack_acc) begin
            if (sat) ovf_set = 1'b1;
            else     debt_d  = debt_q + 4'd1;
        end else if (ack_acc && !tick) begin
            debt_d = debt_q - 4'd1;
        end
        overflow_d = (overflow_q & ~ovf_clr) | ovf_set;
    end

    always_comb begin
        state_d = state_q;
        if (!init_done) begin
            state_d = ST_IDLE;
        end else begin
            unique case (state_q)
                ST_IDLE: if (enable_q && debt_q != 4'd0 &&
                             (!busy || debt_q >= 4'(URGENT_LEVEL)))
                             state_d = ST_REQ;
                ST_REQ:  if (refresh_ack) state_d = ST_HOLD;
                ST_HOLD: if (hold_done) state_d = ST_IDLE;
                default: state_d = ST_IDLE;
            endcase
        end
        req_d = (state_d == ST_REQ);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            enable_q   <= 1'b1;
            trefi_q    <= CNT_BITS'(TREFI_DEFAULT);
            trfc_q     <= 7'(TRFC_DEFAULT);
            debt_q     <= 4'd0;
            overflow_q <= 1'b0;
            req_q      <= 1'b0;
            rdata_q    <= 16'd0;
            state_q    <= ST_IDLE;
        end else begin
            enable_q   <= enable_d;
            trefi_q    <= trefi_d;
            trfc_q     <= trfc_d;
            debt_q     <= debt_d;
            overflow_q <= overflow_d;
            req_q      <= req_d;
            rdata_q    <= rdata_d;
            state_q    <= state_d;
        end
    end

    assign cfg_rdata   = rdata_q;
    assign refresh_req = req_q;
    assign debt        = debt_q;
    assign overflow    = overflow_q;

endmodule

// File: tb/tb_ddr2_refresh_scheduler.sv
// Scoreboard bench for ddr2_refresh_scheduler against a behavioural
// model of refresh debt, interval timing and the CSR map.
module tb_ddr2_refresh_scheduler;

    logic        clk = 1'b0;
    logic        reset;
    logic        init_done;
    logic        busy;
    logic        cfg_wr;
    logic [1:0]  cfg_addr;
    logic [15:0] cfg_wdata;
    logic [15:0] cfg_rdata;
    logic        refresh_req;
    logic        refresh_ack;
    logic [3:0]  debt;
    logic        overflow;

    ddr2_refresh_scheduler dut (
        .clk         (clk),
        .reset       (reset),
        .init_done   (init_done),
        .busy        (busy),
        .cfg_wr      (cfg_wr),
        .cfg_addr    (cfg_addr),
        .cfg_wdata   (cfg_wdata),
        .cfg_rdata   (cfg_rdata),
        .refresh_req (refresh_req),
        .refresh_ack (refresh_ack),
        .debt        (debt),
        .overflow    (overflow)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        req;
        logic [3:0]  debt;
        logic        ovf;
        logic [15:0] rdata;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e, mon_g;
    int   n_tests = 0;
    int   n_fail  = 0;
    int   cyc     = 0;

    // Model state: phase 0 idle, 1 requesting, 2 holding off.
    int m_cnt = 1169, m_trefi = 1170, m_trfc = 16;
    int m_debt = 0, m_phase = 0, m_hold = 0, m_rdata = 0;
    bit m_en = 1, m_ovf = 0;

    bit hold_ack = 0, spurious = 0;
    int ack_dly = 3, req_wait = 0, busy_pct = 0;

    task automatic model_edge();
        int  rd, nphase, wd;
        bit  tick, acc, oset, oclr;
        case (cfg_addr)
            2'd0:    rd = (int'(m_ovf) << 8) | int'(m_en);
            2'd1:    rd = m_trefi;
            2'd2:    rd = m_trfc;
            default: rd = (m_phase << 4) | m_debt;
        endcase
        if (reset) begin
            m_cnt = 1169; m_trefi = 1170; m_trfc = 16;
            m_debt = 0; m_phase = 0; m_hold = 0;
            m_en = 1; m_ovf = 0; m_rdata = 0;
        end else begin
            tick = init_done && m_en && m_cnt == 0;
            acc  = init_done && m_phase == 1 && refresh_ack;
            nphase = m_phase;
            if (!init_done) nphase = 0;
            else if (m_phase == 0) begin
                if (m_en && m_debt > 0 && (!busy || m_debt >= 6))
                    nphase = 1;
            end else if (m_phase == 1) begin
                if (refresh_ack) begin
                    nphase = 2;
                    m_hold = (m_trfc == 0) ? 1 : m_trfc;
                end
            end else begin
                m_hold--;
                if (m_hold == 0) nphase = 0;
            end
            if (!init_done) m_cnt = m_trefi - 1;
            else if (m_en) m_cnt = (m_cnt == 0) ? m_trefi - 1 : m_cnt - 1;
            oset = 0;
            if (!init_done) m_debt = 0;
            else if (tick && !acc) begin
                if (m_debt == 8) oset = 1;
                else m_debt++;
            end else if (acc && !tick) m_debt--;
            oclr = 0;
            wd = int'(cfg_wdata);
            if (cfg_wr) begin
                case (cfg_addr)
                    2'd0: begin m_en = wd[0]; oclr = wd[8]; end
                    2'd1: m_trefi = (wd < 2) ? 2 : wd;
                    2'd2: m_trfc = wd & 127;
                    default: ;
                endcase
            end
            m_ovf = (m_ovf && !oclr) || oset;
            m_phase = nphase;
            m_rdata = rd;
        end
        sb.push_back({m_phase == 1, 4'(m_debt), m_ovf, 16'(m_rdata)});
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        if (m_phase == 1) begin
            refresh_ack = !hold_ack && req_wait >= ack_dly;
            req_wait++;
        end else begin
            req_wait = 0;
            refresh_ack = spurious && ($urandom_range(0, 7) == 0);
        end
    endtask

    task automatic csr_write(input logic [1:0] a, input int d);
        cfg_wr = 1'b1;
        cfg_addr = a;
        cfg_wdata = 16'(d);
        step();
        cfg_wr = 1'b0;
    endtask

    task automatic run(input int n, input bit rnd);
        for (int i = 0; i < n; i++) begin
            if (rnd) begin
                busy = ($urandom_range(0, 99) < busy_pct);
                cfg_addr = 2'($urandom_range(0, 3));
                if (init_done) init_done = ($urandom_range(0, 599) != 0);
                else init_done = ($urandom_range(0, 3) == 0);
            end
            step();
        end
    endtask

    always @(negedge clk) begin
        cyc++;
        if (sb.size() > 0) begin
            mon_e = sb.pop_front();
            mon_g = {refresh_req, debt, overflow, cfg_rdata};
            n_tests++;
            if (mon_g !== mon_e) begin
                n_fail++;
                $display("FAIL outputs @%0d: got req=%0b debt=%0d ovf=%0b rdata=%h, want req=%0b debt=%0d ovf=%0b rdata=%h",
                         cyc, mon_g.req, mon_g.debt, mon_g.ovf, mon_g.rdata,
                         mon_e.req, mon_e.debt, mon_e.ovf, mon_e.rdata);
            end
        end
    end

    initial begin
        reset = 1'b1; init_done = 1'b1; busy = 1'b0;
        cfg_wr = 1'b0; cfg_addr = 2'd3; cfg_wdata = 16'd0;
        refresh_ack = 1'b0;
        run(3, 0);
        reset = 1'b0;
        run(2, 0);

        // Periodic refresh, no traffic, ack 3 clks after request.
        csr_write(2'd1, 100);
        cfg_addr = 2'd3;
        run(1000, 0);

        // Continuous traffic: debt builds until forced, then drains.
        csr_write(2'd1, 50);
        cfg_addr = 2'd3;
        busy = 1'b1;
        run(600, 0);
        busy = 1'b0;
        run(300, 0);

        // Withheld ack: debt saturates and overflow sticks.
        busy = 1'b1; hold_ack = 1;
        cfg_addr = 2'd0;
        run(560, 0);
        csr_write(2'd0, 16'h0100);
        cfg_addr = 2'd0;
        hold_ack = 0;
        run(40, 0);
        csr_write(2'd0, 1);
        busy = 1'b0;
        run(300, 0);

        // TREFI=0 written mid-count clamps to 2 at the next reload.
        run(17, 0);
        csr_write(2'd1, 0);
        cfg_addr = 2'd1;
        run(120, 0);
        csr_write(2'd1, 100);
        run(400, 0);

        // Reset while requesting.
        csr_write(2'd1, 30);
        hold_ack = 1;
        cfg_addr = 2'd3;
        run(45, 0);
        reset = 1'b1;
        run(1, 0);
        reset = 1'b0;
        hold_ack = 0;
        run(2, 0);
        cfg_addr = 2'd1;
        run(2, 0);

        // Randomized segments.
        spurious = 1;
        for (int s = 0; s < 30; s++) begin
            csr_write(2'd1, $urandom_range(0, 40));
            csr_write(2'd2, $urandom_range(0, 20));
            csr_write(2'd0, ($urandom_range(0, 1) << 8) |
                            int'($urandom_range(0, 3) != 0));
            ack_dly  = $urandom_range(0, 5);
            hold_ack = ($urandom_range(0, 7) == 0);
            busy_pct = $urandom_range(0, 100);
            run(300, 1);
        end
        init_done = 1'b1;
        run(3, 0);

        @(negedge clk);
        #1;
        n_tests++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL drain: %0d entries left, want 0", sb.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
